// File: rtl/cam_i2c_arbiter_if.sv
// Bus bundle between the two camera I2C masters and cam_i2c_arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface cam_i2c_arbiter_if;
    logic [1:0] iREQ;
    logic [1:0] iDONE;
    logic [1:0] iSCL;
    logic [1:0] oGNT;
    logic       oSCL;
    logic       oBUSY;
    logic       oTIMEOUT;

    modport master (
        output iREQ, iDONE, iSCL,
        input  oGNT, oSCL, oBUSY, oTIMEOUT
    );

    modport slave (
        input  iREQ, iDONE, iSCL,
        output oGNT, oSCL, oBUSY, oTIMEOUT
    );
endinterface

// File: rtl/cam_i2c_arbiter.sv
// Round-robin arbiter sharing the camera I2C SCL pad between two masters, with a guard gap between grants.
// Optional grant watchdog is compiled in with macro CAM_I2C_ARB_WATCHDOG_EN.
module cam_i2c_arbiter #(
    parameter int GUARD_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    cam_i2c_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    localparam int GW = $clog2(GUARD_CYCLES + 1);

    if (GUARD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cam_i2c_arbiter: GUARD_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    state_t        state;
    state_t        next_state;
    logic [1:0]    gnt;
    logic [1:0]    next_gnt;
    logic          ptr;
    logic          next_ptr;
    logic          busy;
    logic          next_busy;
    logic [GW-1:0] guard_cnt;
    logic          guard_end;
    logic          release_evt;
    logic          timeout_evt;

    // Only the granted master's done/request lines can end a grant.
    assign release_evt = |(gnt & (bus.iDONE | ~bus.iREQ));
    assign guard_end   = (guard_cnt == GW'(GUARD_CYCLES - 1));

`ifdef CAM_I2C_ARB_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt;
    logic          tout;

    assign timeout_evt = (state == GRANT) && !release_evt &&
                         (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wd_cnt <= '0;
            tout   <= 1'b0;
        end else begin
            tout <= timeout_evt;
            if (state == GRANT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign bus.oTIMEOUT = tout;
`else
    assign timeout_evt  = 1'b0;
    assign bus.oTIMEOUT = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
            gnt   <= 2'b00;
            ptr   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            gnt   <= next_gnt;
            ptr   <= next_ptr;
            busy  <= next_busy;
        end
    end

    // Counter is held at zero outside GUARD so every GUARD entry starts fresh.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            guard_cnt <= '0;
        end else if (state != GUARD) begin
            guard_cnt <= '0;
        end else if (!guard_end) begin
            guard_cnt <= guard_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|bus.iREQ) next_state = GRANT;
            GRANT:   if (release_evt || timeout_evt) next_state = GUARD;
            GUARD:   if (guard_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ptr names the master favoured on a tie; it always points away from the last grantee.
    always_comb begin
        next_gnt  = gnt;
        next_ptr  = ptr;
        next_busy = (next_state != IDLE);
        if (state == IDLE && next_state == GRANT) begin
            if (bus.iREQ == 2'b11) begin
                next_gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                next_gnt = bus.iREQ;
            end
            next_ptr = ~next_gnt[1];
        end else if (next_state != GRANT) begin
            next_gnt = 2'b00;
        end
    end

    assign bus.oGNT  = gnt;
    assign bus.oBUSY = busy;

    // SCL is muxed from the registered grant so it tracks the owner's line without a cycle of lag.
    assign bus.oSCL = gnt[0] ? bus.iSCL[0] :
                      gnt[1] ? bus.iSCL[1] : 1'b1;
endmodule

// File: tb/tb_cam_i2c_arbiter.sv
// Self-checking bench for cam_i2c_arbiter: directed vectors plus a per-cycle behavioural model.
// Watchdog scenario is selected by macro CAM_I2C_ARB_WATCHDOG_EN.
module tb_cam_i2c_arbiter;
    localparam int GUARD   = 250;
    localparam int TIMEOUT = 100;
`ifdef CAM_I2C_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   check_en = 1'b0;

    cam_i2c_arbiter_if bus ();

    cam_i2c_arbiter #(
        .GUARD_CYCLES   (GUARD),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus, how long they have held it, guard cycles still to run.
    int m_owner = -1;
    int m_last  = 1;
    int m_guard = 0;
    int m_len   = 0;
    bit m_tout  = 1'b0;

    task automatic model_step();
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 1;
            m_guard = 0;
            m_len   = 0;
            m_tout  = 1'b0;
        end else begin
            m_tout = 1'b0;
            if (m_owner >= 0) begin
                if (bus.iDONE[m_owner] || !bus.iREQ[m_owner]) begin
                    m_owner = -1;
                    m_guard = GUARD;
                end else if (WD && m_len == TIMEOUT) begin
                    m_owner = -1;
                    m_guard = GUARD;
                    m_tout  = 1'b1;
                end else begin
                    m_len++;
                end
            end else if (m_guard > 0) begin
                m_guard--;
            end else if (bus.iREQ != 2'b00) begin
                if (bus.iREQ == 2'b11) m_owner = 1 - m_last;
                else                   m_owner = bus.iREQ[1] ? 1 : 0;
                m_last = m_owner;
                m_len  = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    task automatic check_output(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            check_output("model gnt", bus.oGNT,
                         (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00);
            check_output("model scl", {1'b0, bus.oSCL},
                         {1'b0, (m_owner >= 0) ? bus.iSCL[m_owner] : 1'b1});
            check_output("model busy", {1'b0, bus.oBUSY},
                         {1'b0, (m_owner >= 0) || (m_guard > 0)});
            check_output("model timeout", {1'b0, bus.oTIMEOUT}, {1'b0, m_tout});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [1:0] req, input logic [1:0] done, input logic [1:0] scl);
        bus.iREQ  = req;
        bus.iDONE = done;
        bus.iSCL  = scl;
    endtask

    initial begin
        apply_stimulus(2'b00, 2'b00, 2'b11);
        tick(3);
        check_en = 1'b1;
        check_output("reset gnt", bus.oGNT, 2'b00);
        check_output("reset scl", {1'b0, bus.oSCL}, 2'b01);
        check_output("reset busy", {1'b0, bus.oBUSY}, 2'b00);
        check_output("reset timeout", {1'b0, bus.oTIMEOUT}, 2'b00);
        rst_n = 1'b1;
        tick(2);

        // Single request from master 0, SCL follows master 0
        apply_stimulus(2'b01, 2'b00, 2'b10);
        tick(1);
        check_output("m0 grant", bus.oGNT, 2'b01);
        check_output("m0 scl low", {1'b0, bus.oSCL}, 2'b00);
        bus.iSCL = 2'b01;
        #1;
        check_output("m0 scl high", {1'b0, bus.oSCL}, 2'b01);

        // Non-granted master's done pulse and request are ignored
        apply_stimulus(2'b11, 2'b10, 2'b00);
        tick(1);
        bus.iDONE = 2'b00;
        bus.iREQ  = 2'b01;
        tick(1);
        check_output("ignore m1 done", bus.oGNT, 2'b01);
        check_output("busy in grant", {1'b0, bus.oBUSY}, 2'b01);

        // Done and request drop together: one release, then full guard
        apply_stimulus(2'b00, 2'b01, 2'b00);
        tick(1);
        bus.iDONE = 2'b00;
        check_output("release gnt", bus.oGNT, 2'b00);
        check_output("guard busy", {1'b0, bus.oBUSY}, 2'b01);
        check_output("guard scl", {1'b0, bus.oSCL}, 2'b01);
        tick(GUARD - 1);
        check_output("guard last busy", {1'b0, bus.oBUSY}, 2'b01);
        tick(1);
        check_output("idle busy", {1'b0, bus.oBUSY}, 2'b00);

        // Both request after master 0 was served: master 1 wins
        apply_stimulus(2'b11, 2'b00, 2'b01);
        tick(1);
        check_output("rr grant m1", bus.oGNT, 2'b10);
        check_output("m1 scl", {1'b0, bus.oSCL}, 2'b00);

        // Master 1 done; master 0's held request served after guard
        apply_stimulus(2'b01, 2'b10, 2'b00);
        tick(1);
        bus.iDONE = 2'b00;
        check_output("m1 release", bus.oGNT, 2'b00);
        tick(GUARD - 1);
        check_output("guard hold gnt", bus.oGNT, 2'b00);
        check_output("guard hold scl", {1'b0, bus.oSCL}, 2'b01);
        tick(1);
        check_output("idle before m0", bus.oGNT, 2'b00);
        tick(1);
        check_output("m0 after guard", bus.oGNT, 2'b01);

        // Asynchronous reset mid-grant, then resume from IDLE
        #1;
        rst_n = 1'b0;
        #1;
        check_output("async rst gnt", bus.oGNT, 2'b00);
        check_output("async rst scl", {1'b0, bus.oSCL}, 2'b01);
        check_output("async rst busy", {1'b0, bus.oBUSY}, 2'b00);
        apply_stimulus(2'b10, 2'b00, 2'b11);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check_output("post rst m1", bus.oGNT, 2'b10);
        apply_stimulus(2'b00, 2'b00, 2'b11);
        tick(GUARD + 2);
        check_output("idle again", {1'b0, bus.oBUSY}, 2'b00);

        // Long hold by master 0: watchdog revokes, or grant persists without it
        apply_stimulus(2'b01, 2'b00, 2'b11);
        tick(1);
        check_output("hold grant", bus.oGNT, 2'b01);
`ifdef CAM_I2C_ARB_WATCHDOG_EN
        tick(TIMEOUT - 1);
        check_output("wd last grant", bus.oGNT, 2'b01);
        check_output("wd no pulse yet", {1'b0, bus.oTIMEOUT}, 2'b00);
        tick(1);
        check_output("wd revoke gnt", bus.oGNT, 2'b00);
        check_output("wd pulse", {1'b0, bus.oTIMEOUT}, 2'b01);
        check_output("wd guard busy", {1'b0, bus.oBUSY}, 2'b01);
        tick(1);
        check_output("wd pulse end", {1'b0, bus.oTIMEOUT}, 2'b00);
`else
        tick(TIMEOUT + 50);
        check_output("no wd gnt", bus.oGNT, 2'b01);
        check_output("no wd timeout", {1'b0, bus.oTIMEOUT}, 2'b00);
`endif
        apply_stimulus(2'b00, 2'b00, 2'b11);
        tick(GUARD + 3);
        check_output("final idle", {1'b0, bus.oBUSY}, 2'b00);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_i2c_arbiter.md
CAM_I2C_ARBITER -- requirements
Module: cam_i2c_arbiter

Interface
REQ-001 The block SHALL have parameter GUARD_CYCLES, default 250, giving the number of idle cycles with the bus released between grants (5 us at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 2500000, giving the maximum grant length in cycles (50 ms at 50 MHz), used only when the watchdog is compiled in.
REQ-003 The block SHALL have port iCLK, input, 1 bit: the single clock, CLOCK2_50 domain.
REQ-004 The block SHALL have port iRST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port iREQ, input, 2 bits: bus request per master (bit0 = MIPI bridge/camera config, bit1 = autofocus), level-held.
REQ-006 The block SHALL have port iDONE, input, 2 bits: single-cycle pulse per master ending its transaction.
REQ-007 The block SHALL have port iSCL, input, 2 bits: SCL drive value per master.
REQ-008 The block SHALL have port oGNT, input... correction, output, 2 bits: one-hot-or-zero grant.
REQ-009 The block SHALL have port oSCL, output, 1 bit: arbitrated SCL toward the camera I2C pad.
REQ-010 The block SHALL have port oBUSY, output, 1 bit: high in GRANT or GUARD.
REQ-011 The block SHALL have port oTIMEOUT, output, 1 bit: single-cycle watchdog-revoke pulse.

Function
REQ-012 The block SHALL implement FSM states IDLE, GRANT and GUARD, all outputs registered.
REQ-013 In IDLE with any iREQ bit high, the block SHALL enter GRANT on the next edge with oGNT one-hot; latency from request to grant SHALL be exactly 1 cycle.
REQ-014 When both requests are high, the block SHALL grant the master not granted last (round-robin pointer); the pointer reset value SHALL favour master 0.
REQ-015 In GRANT, oGNT SHALL hold until the granted master's iDONE pulses or its iREQ drops, then the block SHALL go to GUARD with oGNT=0 on the next edge.
REQ-016 If iDONE and iREQ drop in the same cycle, the block SHALL treat them as one release event.
REQ-017 iDONE or iREQ activity of the non-granted master SHALL be ignored during GRANT; its held request SHALL be served after GUARD.
REQ-018 GUARD SHALL last exactly GUARD_CYCLES cycles and then return to IDLE; a request pending at that point SHALL be granted 1 cycle later.
REQ-019 oSCL SHALL equal iSCL of the granted master in GRANT and SHALL be 1 (released) in IDLE and GUARD.
REQ-020 The guard counter SHALL be wide enough for GUARD_CYCLES with no wrap, and SHALL clear on every entry to GUARD.

Reset
REQ-021 On iRST_N low, the block SHALL force state=IDLE, oGNT=0, oSCL=1, oBUSY=0, oTIMEOUT=0, counters=0 and pointer=master 0, immediately and asynchronously.
REQ-022 Reset asserted mid-GRANT SHALL drop the grant with no GUARD period; after release, the block SHALL resume from IDLE.

Configuration
REQ-023 With macro CAM_I2C_ARB_WATCHDOG_EN defined, the block SHALL count cycles in GRANT; on reaching TIMEOUT_CYCLES it SHALL revoke the grant, pulse oTIMEOUT for 1 cycle, advance the pointer and enter GUARD.
REQ-024 Without CAM_I2C_ARB_WATCHDOG_EN, the block SHALL omit the watchdog counter, tie oTIMEOUT to 0, and hold grants indefinitely.

Verification
REQ-025 The bench SHALL apply reset, then iREQ=2'b01 -> oGNT=2'b01 after 1 cycle, oSCL follows iSCL[0].
REQ-026 The bench SHALL raise iREQ=2'b11 from IDLE after a prior grant to master 0 -> oGNT=2'b10; after iDONE[1], GUARD for 250 cycles with oSCL=1, then oGNT=2'b01.
REQ-027 The bench SHALL pulse iDONE[1] while master 0 is granted -> no state change, oGNT stays 2'b01.
REQ-028 The bench SHALL assert iRST_N low mid-GRANT -> oGNT=0 and oSCL=1 immediately; after release with iREQ=2'b10, oGNT=2'b10 1 cycle later.
REQ-029 With CAM_I2C_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=100, the bench SHALL hold iREQ=2'b01 with no iDONE -> oTIMEOUT pulses at cycle 100 of GRANT, oGNT=0, then GUARD.
